// File: rtl/dcache_flush_sequencer.sv
// Data cache flush sequencer: walks every set, hands valid+dirty lines to the
// miss handler as writebacks, then clears valid/dirty for the whole set.
module dcache_flush_sequencer #(
    parameter int unsigned  NUM_SETS  = 256,
    parameter int unsigned  SET_ASSOC = 8,
    parameter int unsigned  TAG_WIDTH = 44,
    localparam int unsigned IDX_WIDTH = $clog2(NUM_SETS),
    localparam int unsigned WAY_WIDTH = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           inval_only_i,
    output logic                           flush_ack_o,
    output logic                           busy_o,
    output logic [SET_ASSOC-1:0]           sram_req_o,
    input  logic                           sram_gnt_i,
    output logic                           sram_we_o,
    output logic [IDX_WIDTH-1:0]           sram_idx_o,
    input  logic [SET_ASSOC-1:0]           sram_valid_i,
    input  logic [SET_ASSOC-1:0]           sram_dirty_i,
    input  logic [SET_ASSOC*TAG_WIDTH-1:0] sram_tag_i,
    output logic                           wb_valid_o,
    input  logic                           wb_ready_i,
    output logic [TAG_WIDTH-1:0]           wb_tag_o,
    output logic [IDX_WIDTH-1:0]           wb_idx_o,
    output logic [WAY_WIDTH-1:0]           wb_way_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SETS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WB   = 3'd3,
        CLR  = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e                         state_q, state_d;
    logic [IDX_WIDTH-1:0]           idx_q, idx_d;
    logic                           armed_q, armed_d;
    logic                           inval_q, inval_d;
    logic [SET_ASSOC-1:0]           pend_q, pend_d;
    logic [SET_ASSOC*TAG_WIDTH-1:0] tags_q, tags_d;
    logic [WAY_WIDTH-1:0]           cur_way, nxt_way;

    // Registered output images, computed from the next state
    logic                           ack_q, ack_d;
    logic                           busy_q, busy_d;
    logic [SET_ASSOC-1:0]           req_q, req_d;
    logic                           we_q, we_d;
    logic [IDX_WIDTH-1:0]           sidx_q, sidx_d;
    logic                           wbv_q, wbv_d;
    logic [TAG_WIDTH-1:0]           wbt_q, wbt_d;
    logic [IDX_WIDTH-1:0]           wbi_q, wbi_d;
    logic [WAY_WIDTH-1:0]           wbw_q, wbw_d;

    // Lowest set bit of a pending-writeback vector
    function automatic logic [WAY_WIDTH-1:0] lowest_way(input logic [SET_ASSOC-1:0] vec);
        logic [WAY_WIDTH-1:0] way;
        way = '0;
        for (int i = SET_ASSOC - 1; i >= 0; i--) begin
            if (vec[i]) way = WAY_WIDTH'(i);
        end
        return way;
    endfunction

    assign cur_way = lowest_way(pend_q);
    assign nxt_way = lowest_way(pend_d);

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        inval_d = inval_q;
        pend_d  = pend_q;
        tags_d  = tags_q;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        req_d   = '0;
        we_d    = 1'b0;
        sidx_d  = '0;
        wbv_d   = 1'b0;
        wbt_d   = '0;
        wbi_d   = '0;
        wbw_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (flush_i && armed_q) begin
                    inval_d = inval_only_i;
                    idx_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (sram_gnt_i) state_d = RD;
            end
            RD: begin
                tags_d  = sram_tag_i;
                pend_d  = sram_valid_i & sram_dirty_i & {SET_ASSOC{~inval_q}};
                state_d = (pend_d != '0) ? WB : CLR;
            end
            WB: begin
                if (wb_ready_i) begin
                    pend_d[cur_way] = 1'b0;
                    if (pend_d == '0) state_d = CLR;
                end
            end
            CLR: begin
                if (sram_gnt_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = IDX_WIDTH'(idx_q + 1'b1);
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                armed_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A low flush_i always re-arms, so a held request cannot restart the walk
        if (!flush_i) armed_d = 1'b1;

        busy_d = (state_d != IDLE);
        ack_d  = (state_d == DONE);
        if (state_d == REQ || state_d == CLR) begin
            req_d  = '1;
            we_d   = (state_d == CLR);
            sidx_d = idx_d;
        end
        if (state_d == WB) begin
            wbv_d = 1'b1;
            wbi_d = idx_d;
            wbw_d = nxt_way;
            for (int w = 0; w < SET_ASSOC; w++) begin
                if (WAY_WIDTH'(w) == nxt_way) wbt_d = tags_d[w*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // State, walk context and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            armed_q <= 1'b1;
            inval_q <= 1'b0;
            pend_q  <= '0;
            tags_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= '0;
            we_q    <= 1'b0;
            sidx_q  <= '0;
            wbv_q   <= 1'b0;
            wbt_q   <= '0;
            wbi_q   <= '0;
            wbw_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            armed_q <= armed_d;
            inval_q <= inval_d;
            pend_q  <= pend_d;
            tags_q  <= tags_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            we_q    <= we_d;
            sidx_q  <= sidx_d;
            wbv_q   <= wbv_d;
            wbt_q   <= wbt_d;
            wbi_q   <= wbi_d;
            wbw_q   <= wbw_d;
        end
    end

    assign flush_ack_o = ack_q;
    assign busy_o      = busy_q;
    assign sram_req_o  = req_q;
    assign sram_we_o   = we_q;
    assign sram_idx_o  = sidx_q;
    assign wb_valid_o  = wbv_q;
    assign wb_tag_o    = wbt_q;
    assign wb_idx_o    = wbi_q;
    assign wb_way_o    = wbw_q;

endmodule
